// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared definitions for the instruction fetch sequencer:
//               FSM state encoding, instruction size, default reset vector
//               and the wait-timer width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Counter width able to hold TIMEOUT_CYCLES; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : ifu_wait_timer
// Description : Clear/enable cycle counter that flags the cycle on which an
//               outstanding memory request has waited TIMEOUT_CYCLES cycles.
//               With TIMEOUT_CYCLES == 0 the expired flag is held low.
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset
//               i_clr     - synchronous clear (has priority over i_en)
//               i_en      - count this cycle
//               o_expired - this enabled cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_wait_timer
    import ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned c_W       = timer_width(TIMEOUT_CYCLES);
    localparam logic        c_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [c_W-1:0] c_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : c_W'(TIMEOUT_CYCLES - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flag the enabled cycle whose increment would bring the count to
    // TIMEOUT_CYCLES, so the owner leaves WAIT on that same edge.
    assign o_expired = c_ENABLED & i_en & (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_sequencer
// Description : Instruction fetch sequencer. Owns the fetch PC, issues one
//               instruction-memory request at a time, captures the response
//               into the IR and offers it to decode with valid/ready.
//               Handles branch redirect (discarding an in-flight response),
//               halt, and a sticky response-timeout fault.
// Ports       : ifs_clock_in/ifs_reset_in   - clock, async active-low reset
//               halt_in, branch_taken_in,
//               branch_target_in            - control from the core
//               imem_req_out/imem_addr_out,
//               imem_ready_in/imem_valid_in,
//               imem_data_in                - instruction memory port
//               ir_valid_out/ir_data_out/
//               ir_pc_out, id_ready_in      - decode handshake
//               pc_out, halted_out,
//               fetch_fault_out             - status
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_sequencer
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        ifs_clock_in,
    input  logic        ifs_reset_in,
    input  logic        halt_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        imem_ready_in,
    input  logic        imem_valid_in,
    input  logic [31:0] imem_data_in,
    input  logic        id_ready_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic        ir_valid_out,
    output logic [31:0] ir_data_out,
    output logic [31:0] ir_pc_out,
    output logic [31:0] pc_out,
    output logic        halted_out,
    output logic        fetch_fault_out
);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir_data;
    logic [31:0] r_ir_pc;
    logic        r_ir_valid;
    logic        r_discard;
    logic        r_fault;

    logic [31:0] w_target;
    logic        w_timeout;
    logic        w_load_target;
    logic        w_capture;
    logic        w_set_discard;
    logic        w_clr_discard;
    logic        w_flush;
    logic        w_enter_fault;

    assign w_target = branch_target_in & ~32'h0000_0003;

    ifu_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (ifs_clock_in),
        .rst_n     (ifs_reset_in),
        .i_clr     (r_state != WAIT),
        .i_en      ((r_state == WAIT) && !imem_valid_in),
        .o_expired (w_timeout)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ifs_clock_in or negedge ifs_reset_in) begin
        if (!ifs_reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_load_target = 1'b0;
        w_capture     = 1'b0;
        w_set_discard = 1'b0;
        w_clr_discard = 1'b0;
        w_flush       = 1'b0;
        w_enter_fault = 1'b0;

        case (r_state)
            IDLE: begin
                w_load_target = branch_taken_in;
                w_next_state  = halt_in ? HALT : REQ;
            end

            REQ: begin
                if (imem_ready_in) begin
                    // Accepted: a branch on this edge makes the response stale.
                    w_next_state  = WAIT;
                    w_load_target = branch_taken_in;
                    w_set_discard = branch_taken_in;
                end else if (branch_taken_in) begin
                    w_load_target = 1'b1;
                end else if (halt_in) begin
                    w_next_state = HALT;
                end
            end

            WAIT: begin
                if (imem_valid_in) begin
                    w_clr_discard = 1'b1;
                    if (branch_taken_in || r_discard) begin
                        w_load_target = branch_taken_in;
                        w_next_state  = halt_in ? HALT : REQ;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = HOLD;
                    end
                end else begin
                    // Response still owed: redirect now, drop it on arrival.
                    w_load_target = branch_taken_in;
                    w_set_discard = branch_taken_in;
                    if (w_timeout) begin
                        w_enter_fault = 1'b1;
                        w_next_state  = FAULT;
                    end
                end
            end

            HOLD: begin
                if (branch_taken_in || id_ready_in) begin
                    w_flush       = 1'b1;
                    w_load_target = branch_taken_in;
                    w_next_state  = halt_in ? HALT : REQ;
                end
            end

            HALT: begin
                if (branch_taken_in) begin
                    w_load_target = 1'b1;
                end else if (!halt_in) begin
                    w_next_state = REQ;
                end
            end

            FAULT: begin
                w_next_state = FAULT;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC / IR / flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge ifs_clock_in or negedge ifs_reset_in) begin
        if (!ifs_reset_in) begin
            r_pc       <= RESET_VECTOR;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_discard  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (w_load_target) begin
                r_pc <= w_target;
            end else if (w_capture) begin
                r_pc <= r_pc + 32'(INSTR_BYTES);
            end

            if (w_capture) begin
                r_ir_data  <= imem_data_in;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
            end else if (w_flush || w_enter_fault) begin
                r_ir_valid <= 1'b0;
            end

            if (w_set_discard) begin
                r_discard <= 1'b1;
            end else if (w_clr_discard || w_enter_fault) begin
                r_discard <= 1'b0;
            end

            if (w_enter_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_out    = (r_state == REQ);
        halted_out      = (r_state == HALT);
        imem_addr_out   = r_pc;
        pc_out          = r_pc;
        ir_valid_out    = r_ir_valid;
        ir_data_out     = r_ir_data;
        ir_pc_out       = r_ir_pc;
        fetch_fault_out = r_fault;
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_sequencer
// Description : Directed, table-driven bench for ifu_fetch_sequencer plus
//               hand-written reset and timeout sequences. A second instance
//               with the timeout disabled shares all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        vld;
    logic [31:0] dat;
    logic        idr;

    logic        req,  req_n;
    logic [31:0] addr, addr_n;
    logic        irv,  irv_n;
    logic [31:0] ird,  ird_n;
    logic [31:0] irpc, irpc_n;
    logic [31:0] pc,   pc_n;
    logic        hlt,  hlt_n;
    logic        flt,  flt_n;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_sequencer #(
        .RESET_VECTOR   (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ifs_clock_in     (clk),
        .ifs_reset_in     (rst_n),
        .halt_in          (halt),
        .branch_taken_in  (br),
        .branch_target_in (tgt),
        .imem_ready_in    (rdy),
        .imem_valid_in    (vld),
        .imem_data_in     (dat),
        .id_ready_in      (idr),
        .imem_req_out     (req),
        .imem_addr_out    (addr),
        .ir_valid_out     (irv),
        .ir_data_out      (ird),
        .ir_pc_out        (irpc),
        .pc_out           (pc),
        .halted_out       (hlt),
        .fetch_fault_out  (flt)
    );

    ifu_fetch_sequencer #(
        .RESET_VECTOR   (32'h0000_0000),
        .TIMEOUT_CYCLES (0)
    ) dut_notmo (
        .ifs_clock_in     (clk),
        .ifs_reset_in     (rst_n),
        .halt_in          (halt),
        .branch_taken_in  (br),
        .branch_target_in (tgt),
        .imem_ready_in    (rdy),
        .imem_valid_in    (vld),
        .imem_data_in     (dat),
        .id_ready_in      (idr),
        .imem_req_out     (req_n),
        .imem_addr_out    (addr_n),
        .ir_valid_out     (irv_n),
        .ir_data_out      (ird_n),
        .ir_pc_out        (irpc_n),
        .pc_out           (pc_n),
        .halted_out       (hlt_n),
        .fetch_fault_out  (flt_n)
    );

    typedef struct {
        logic        halt;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_irv;
        logic [31:0] e_irpc;
        logic [31:0] e_ird;
        logic        e_hlt;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic h, input logic b, input logic [31:0] t,
        input logic r, input logic v, input logic [31:0] d, input logic i,
        input logic er, input logic [31:0] ea, input logic ev,
        input logic [31:0] ep, input logic [31:0] ed, input logic eh);
        vec_t x;
        x.halt = h;  x.br = b;  x.tgt = t;  x.rdy = r;  x.vld = v;
        x.dat = d;   x.idr = i;
        x.e_req = er; x.e_addr = ea; x.e_irv = ev;
        x.e_irpc = ep; x.e_ird = ed; x.e_hlt = eh;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        halt = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b0; vld = 1'b0; dat = '0; idr = 1'b1;
    endtask

    initial begin
        logic seen_fault_n;
        checks   = 0;
        failures = 0;
        drive_idle();
        rst_n = 1'b0;

        // Inputs are driven and outputs sampled on the falling edge; each row
        // lists the outputs expected for the state occupied that cycle.
        //            halt br tgt        rdy vld dat           idr | req addr       irv irpc       ird           hlt
        tbl[0]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  0, 32'h000,    0, 32'h0,     32'h0,         0);
        tbl[1]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  1, 32'h000,    0, 32'h0,     32'h0,         0);
        tbl[2]  = mk(0, 0, 32'h0,     1, 1, 32'hA000_0000, 1,  0, 32'h000,    0, 32'h0,     32'h0,         0);
        tbl[3]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  0, 32'h004,    1, 32'h000,   32'hA000_0000, 0);
        tbl[4]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  1, 32'h004,    0, 32'h0,     32'h0,         0);
        tbl[5]  = mk(0, 0, 32'h0,     1, 1, 32'hA000_0004, 0,  0, 32'h004,    0, 32'h0,     32'h0,         0);
        tbl[6]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         0,  0, 32'h008,    1, 32'h004,   32'hA000_0004, 0);
        tbl[7]  = mk(0, 0, 32'h0,     1, 1, 32'h1111_1111, 0,  0, 32'h008,    1, 32'h004,   32'hA000_0004, 0);
        tbl[8]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         0,  0, 32'h008,    1, 32'h004,   32'hA000_0004, 0);
        tbl[9]  = mk(0, 0, 32'h0,     1, 0, 32'h0,         0,  0, 32'h008,    1, 32'h004,   32'hA000_0004, 0);
        tbl[10] = mk(0, 0, 32'h0,     1, 0, 32'h0,         0,  0, 32'h008,    1, 32'h004,   32'hA000_0004, 0);
        tbl[11] = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  0, 32'h008,    1, 32'h004,   32'hA000_0004, 0);
        tbl[12] = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  1, 32'h008,    0, 32'h0,     32'h0,         0);
        tbl[13] = mk(0, 1, 32'h103,   0, 0, 32'h0,         1,  0, 32'h008,    0, 32'h0,     32'h0,         0);
        tbl[14] = mk(0, 0, 32'h0,     0, 1, 32'hDEAD_BEEF, 1,  0, 32'h100,    0, 32'h0,     32'h0,         0);
        tbl[15] = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  1, 32'h100,    0, 32'h0,     32'h0,         0);
        tbl[16] = mk(0, 1, 32'h200,   0, 1, 32'hBAD0_0100, 1,  0, 32'h100,    0, 32'h0,     32'h0,         0);
        tbl[17] = mk(0, 0, 32'h0,     1, 0, 32'h0,         1,  1, 32'h200,    0, 32'h0,     32'h0,         0);
        tbl[18] = mk(0, 0, 32'h0,     1, 1, 32'hA000_0200, 1,  0, 32'h200,    0, 32'h0,     32'h0,         0);
        tbl[19] = mk(0, 1, 32'h300,   0, 0, 32'h0,         0,  0, 32'h204,    1, 32'h200,   32'hA000_0200, 0);
        tbl[20] = mk(1, 0, 32'h0,     0, 0, 32'h0,         1,  1, 32'h300,    0, 32'h0,     32'h0,         0);
        tbl[21] = mk(1, 0, 32'h0,     1, 0, 32'h0,         1,  0, 32'h300,    0, 32'h0,     32'h0,         1);
        tbl[22] = mk(0, 0, 32'h0,     0, 0, 32'h0,         1,  0, 32'h300,    0, 32'h0,     32'h0,         1);
        tbl[23] = mk(0, 0, 32'h0,     0, 0, 32'h0,         1,  1, 32'h300,    0, 32'h0,     32'h0,         0);
        tbl[24] = mk(0, 0, 32'h0,     0, 1, 32'h5555_5555, 1,  1, 32'h300,    0, 32'h0,     32'h0,         0);

        repeat (2) @(negedge clk);
        chk("reset pc", pc, 32'h0);
        chk("reset req", {31'b0, req}, 32'h0);
        chk("reset fault", {31'b0, flt}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("row%0d req", i),    {31'b0, req}, {31'b0, tbl[i].e_req});
            chk($sformatf("row%0d addr", i),   addr,         tbl[i].e_addr);
            chk($sformatf("row%0d pc", i),     pc,           tbl[i].e_addr);
            chk($sformatf("row%0d ir_valid", i), {31'b0, irv}, {31'b0, tbl[i].e_irv});
            chk($sformatf("row%0d halted", i), {31'b0, hlt}, {31'b0, tbl[i].e_hlt});
            chk($sformatf("row%0d fault", i),  {31'b0, flt}, 32'h0);
            if (tbl[i].e_irv) begin
                chk($sformatf("row%0d ir_pc", i),   irpc, tbl[i].e_irpc);
                chk($sformatf("row%0d ir_data", i), ird,  tbl[i].e_ird);
            end
            halt = tbl[i].halt; br = tbl[i].br; tgt = tbl[i].tgt;
            rdy  = tbl[i].rdy;  vld = tbl[i].vld; dat = tbl[i].dat; idr = tbl[i].idr;
            @(negedge clk);
        end

        // Reset asserted while a request is outstanding.
        drive_idle();
        rdy = 1'b1;
        @(negedge clk);
        chk("preRst in WAIT req", {31'b0, req}, 32'h0);
        chk("preRst pc", pc, 32'h300);
        #2 rst_n = 1'b0;
        #1;
        chk("rst pc", pc, 32'h0);
        chk("rst addr", addr, 32'h0);
        chk("rst ir_data", ird, 32'h0);
        chk("rst ir_pc", irpc, 32'h0);
        chk("rst ir_valid", {31'b0, irv}, 32'h0);
        chk("rst req", {31'b0, req}, 32'h0);
        chk("rst halted", {31'b0, hlt}, 32'h0);

        // Timeout: request accepted, response never arrives.
        @(negedge clk);
        rst_n = 1'b1;                          // IDLE this cycle
        @(negedge clk);
        chk("tmo REQ", {31'b0, req}, 32'h1);
        @(negedge clk);                        // first WAIT cycle
        repeat (14) @(negedge clk);            // fifteenth WAIT cycle
        chk("tmo 15 no fault", {31'b0, flt}, 32'h0);
        chk("tmo 15 no req", {31'b0, req}, 32'h0);
        repeat (2) @(negedge clk);
        chk("tmo fault", {31'b0, flt}, 32'h1);
        chk("tmo halted", {31'b0, hlt}, 32'h0);

        // Fault is sticky and terminal; the untimed instance never faults.
        seen_fault_n = 1'b0;
        for (int c = 0; c < 100; c++) begin
            br  = (c % 7) == 3;
            tgt = 32'h400;
            vld = (c == 50);
            halt = (c % 11) == 5;
            if (c < 20) begin
                chk($sformatf("fault c%0d req", c), {31'b0, req}, 32'h0);
                chk($sformatf("fault c%0d sticky", c), {31'b0, flt}, 32'h1);
            end
            seen_fault_n = seen_fault_n | flt_n;
            @(negedge clk);
        end
        chk("fault sticky end", {31'b0, flt}, 32'h1);
        chk("fault ir_valid", {31'b0, irv}, 32'h0);
        chk("notmo never faults", {31'b0, seen_fault_n}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch_sequencer.md
Name: ifu_fetch_sequencer

Overview:
- Sequences the instruction fetch unit: owns the fetch PC, issues one instruction-memory request at a time, captures the response into the instruction register (IR), and hands it to decode with a valid/ready handshake.
- Handles branch redirect with flush and discard of any in-flight response, halt, and a memory-response timeout fault.
- Sits between the IFU datapath (PC/IR), the instruction memory port and the decode stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, WAIT cycles without imem_valid_in before FAULT; 0 disables the timeout.

Ports:
- ifs_clock_in  input  1  clock; all state updates on rising edge.
- ifs_reset_in  input  1  asynchronous, active-low reset.
- halt_in  input  1  request halt of fetch.
- branch_taken_in  input  1  redirect the PC this cycle.
- branch_target_in  input  32  redirect target; bits [1:0] are forced to 0.
- imem_ready_in  input  1  memory accepts request this cycle.
- imem_valid_in  input  1  memory response valid this cycle.
- imem_data_in  input  32  response instruction word.
- id_ready_in  input  1  decode accepts IR this cycle.
- imem_req_out  output  1  request valid.
- imem_addr_out  output  32  request address (always equals pc_out).
- ir_valid_out  output  1  IR holds an instruction for decode.
- ir_data_out  output  32  IR instruction word.
- ir_pc_out  output  32  PC of the IR instruction.
- pc_out  output  32  current fetch PC.
- halted_out  output  1  high in HALT state.
- fetch_fault_out  output  1  sticky timeout fault.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; pc = RESET_VECTOR.
  - ir_valid_out, ir_data_out, ir_pc_out, discard flag, timer, fetch_fault_out and halted_out = 0.
  - imem_req_out = 0, since it is decoded from state.
- States:
  - IDLE, REQ, WAIT, HOLD, HALT, FAULT.
  - Only REQ drives imem_req_out = 1.
  - halted_out = (state == HALT).
- Priority within a cycle: reset > branch > halt > normal flow.
- IDLE: next state is HALT if halt_in, otherwise REQ.
- REQ:
  - Request is accepted on an edge with imem_ready_in = 1; next state WAIT.
  - Branch without accept: pc <= target; stay in REQ. The address may change while unaccepted.
  - Branch with accept in the same cycle: pc <= target; set discard; go to WAIT.
  - Halt without accept or branch: go to HALT.
- WAIT:
  - Timer increments each cycle.
  - On imem_valid_in with discard = 0: capture imem_data_in into IR and pc into ir_pc_out; ir_valid <= 1; pc <= pc + 4 (wraps modulo 2^32); go to HOLD.
  - On imem_valid_in with discard = 1: drop the data; clear discard; go to HALT if halt_in, otherwise REQ.
  - Branch during WAIT: pc <= target; set discard.
  - Branch in the same cycle as valid: the response is discarded; pc <= target; go to REQ (or HALT if halt_in).
  - Timer clears on leaving WAIT.
  - If TIMEOUT_CYCLES != 0 and the timer reaches TIMEOUT_CYCLES without valid: go to FAULT; fetch_fault_out <= 1.
- HOLD:
  - ir_valid_out = 1.
  - On id_ready_in: ir_valid <= 0; go to HALT if halt_in, otherwise REQ. No idle bubble.
  - Branch: flush (ir_valid <= 0); pc <= target; go to REQ, or HALT if halt_in.
  - ir_data_out and ir_pc_out stay stable while ir_valid_out = 1 and not accepted.
- HALT:
  - No request.
  - Branch updates pc and stays in HALT.
  - halt_in = 0 moves to REQ on the next edge.
- FAULT:
  - Terminal until reset; no requests.
  - Inputs are ignored.
  - ir_valid_out is cleared on entry.
- Outstanding requests:
  - At most one.
  - A response is never captured while ir_valid_out = 1, guaranteed by construction.
  - A response outside WAIT is ignored.
- Throughput: with zero-latency memory and decode always ready, one instruction per 3 cycles (REQ, WAIT, HOLD).

Decomposition:
- Package ifu_pkg:
  - State encoding localparams: IDLE, REQ, WAIT, HOLD, HALT, FAULT, 3 bits.
  - INSTR_BYTES = 4.
  - Default RESET_VECTOR.
- Sub-module ifu_wait_timer:
  - Clear/enable counter.
  - Width $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Expired output, tied low when TIMEOUT_CYCLES == 0.

Test Plan:
- Reset, then imem_ready = 1 and valid one cycle after accept, id_ready = 1 -> requests at 0x0, 0x4, 0x8 every 3 cycles; ir_pc_out tracks them; ir_data_out equals the memory word.
- HOLD with id_ready = 0 for 5 cycles -> ir_valid_out stays 1 with data/PC stable; no imem_req_out; advances the cycle after id_ready = 1.
- Branch to 0x103 during WAIT (request at 0x8) -> response dropped; next request at 0x100; ir_pc_out never shows 0x8.
- Branch coincident with imem_valid_in, and branch in HOLD -> IR flushed (ir_valid_out = 0 the next cycle); next request at the target.
- halt_in in REQ without ready -> HALTED, halted_out = 1, no requests; deassert -> REQ at the same PC. Reset asserted mid-WAIT -> all outputs 0 immediately, PC = RESET_VECTOR.
- No imem_valid_in for 16 WAIT cycles -> fetch_fault_out = 1, sticky; no further requests until reset. With TIMEOUT_CYCLES = 0 -> never faults over 100 cycles.
